logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one registered WIDTH-bit bitwise logic unit (AND / OR / NOT / optional XOR) between two requesters: requester 0 is the execute-stage ALU path, requester 1 is the branch/compare helper.
- Round-robin arbitration, per-requester grant pulse, and a single result channel held until the owner acknowledges.
- Sits beside the ALU inside the processor core.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 wants an operation (level).
- op0  in  2  requester 0 opcode.
- a0  in  WIDTH  requester 0 operand A.
- b0  in  WIDTH  requester 0 operand B.
- req1  in  1  requester 1 request (level).
- op1  in  2  requester 1 opcode.
- a1  in  WIDTH  requester 1 operand A.
- b1  in  WIDTH  requester 1 operand B.
- result_ack  in  1  current owner consumed the result.
- gnt0  out  1  one-cycle pulse: requester 0 operands latched.
- gnt1  out  1  one-cycle pulse: requester 1 operands latched.
- result  out  WIDTH  registered result.
- result_valid  out  1  result is valid and held.
- result_owner  out  1  index of the requester owning result.
- result_zero  out  1  result == 0; qualified by result_valid.
- op_err  out  1  illegal opcode executed; qualified by result_valid.
- busy  out  1  high in EXEC or DONE.

Behaviour:
- Opcodes:
  - 00 = A AND B
  - 01 = A OR B
  - 10 = NOT A (B ignored)
  - 11 = A XOR B (see Optional Feature)
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, last_owner = 1 (requester 0 wins the first tie).
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - At a rising edge with req0 or req1 high, select a winner:
    - If only one requester is high, it wins.
    - If both are high, the one != last_owner wins.
  - Latch the winner's op/a/b, set last_owner = winner, pulse that requester's gnt for exactly one cycle, go to EXEC.
- EXEC (one cycle):
  - Compute into result.
  - result_valid <= 1; result_owner <= owner; result_zero and op_err updated.
  - Go to DONE.
- DONE:
  - result and all qualifiers are held stable while result_ack = 0.
  - On result_ack = 1, clear result_valid. result may keep its stale value.
    - If any request is high in the same cycle, arbitrate as in IDLE and go straight to EXEC (back-to-back).
    - Otherwise go to IDLE.
- Latency: request high before edge k -> gnt high during cycle k -> result_valid high from edge k+1 onward.
- Throughput: 2 cycles per op with back-to-back ack.
- Requesters must hold op/a/b stable while req is high and until their gnt has been seen. Operands are sampled only at the granting edge.
- result_ack in IDLE or EXEC: ignored.
- req dropped before grant: no grant, no side effects.
- A requester that keeps req high after its grant is treated as a new request. Round-robin guarantees the other requester waits at most one operation.
- busy = (state != IDLE).
- Reset asserted mid-operation: immediate return to reset values. In-flight result discarded, no gnt or result_valid emitted.

Optional Feature:
- Macro LOGIC_ARB_XOR_EN.
- Defined: opcode 11 computes A XOR B, op_err = 0.
- Undefined:
  - opcode 11 is illegal: result = 0, result_zero = 1, op_err = 1, result_valid still asserted.
  - The handshake is unchanged.

Test Plan:
- Reset, then req0 with op0 = 01, a0 = 0x0000_F0F0, b0 = 0x0F0F_0000 -> gnt0 one cycle, next cycle result = 0x0F0F_F0F0, result_owner = 0, result_valid held until result_ack.
- req0 and req1 high in the same cycle with a0 = 0xFFFF_0000, b0 = 0x00FF_FF00 (op0 = 00), a1 = 0x1234_5678 (op1 = 10) -> requester 0 granted first with result 0x00FF_0000; after ack, gnt1 with result = 0xEDCB_A987; then next tie goes to 0.
- op0 = 00, a0 = 0xAAAA_AAAA, b0 = 0x5555_5555 -> result = 0, result_zero = 1.
- op1 = 11, a1 = 0xFFFF_0000, b1 = 0x0F0F_0F0F:
  - With LOGIC_ARB_XOR_EN: result = 0xF0F0_0F0F, op_err = 0.
  - Without it: result = 0, op_err = 1.
- Hold result_ack = 0 for 5 cycles while req1 stays high -> result stable, no gnt1, busy = 1; ack with req1 high -> gnt1 in the same cycle, result_valid deasserted for exactly one cycle.
- Assert reset during EXEC -> all outputs 0 on the same cycle, no result_valid after release; a subsequent request completes normally.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// ============================================================================
// logic_unit_arbiter
//
// Purpose:
//   Shares one registered WIDTH-bit bitwise logic unit between two requesters.
//   Requester 0 is the execute-stage ALU path. Requester 1 is the
//   branch/compare helper. Ties are broken round-robin. The winner sees a
//   one-cycle grant pulse when its operands are latched. A single result
//   channel is then held until the owner acknowledges it.
//
//   Opcodes: 00 = A AND B, 01 = A OR B, 10 = NOT A, 11 = A XOR B (optional).
//
// Configuration:
//   LOGIC_ARB_XOR_EN  When defined, opcode 11 computes A XOR B.
//                     When undefined, opcode 11 is illegal: the result is 0,
//                     o_result_zero is 1, and o_op_err is 1.
//
// Ports:
//   i_clock          system clock, rising edge
//   i_reset          asynchronous, active-high reset
//   i_req0/i_req1    request levels from requester 0 / 1
//   i_op0/i_op1      2-bit opcodes
//   i_a0/i_b0        requester 0 operands (WIDTH bits)
//   i_a1/i_b1        requester 1 operands (WIDTH bits)
//   i_result_ack     current owner consumed the result
//   o_gnt0/o_gnt1    one-cycle pulse: that requester's operands were latched
//   o_result         registered result (WIDTH bits)
//   o_result_valid   result valid and held
//   o_result_owner   index of the requester owning the result
//   o_result_zero    result == 0 (qualified by o_result_valid)
//   o_op_err         illegal opcode executed (qualified by o_result_valid)
//   o_busy           high while in EXEC or DONE
// ============================================================================
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_req0,
    input  logic [1:0]       i_op0,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_b0,
    input  logic             i_req1,
    input  logic [1:0]       i_op1,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    input  logic             i_result_ack,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output logic [WIDTH-1:0] o_result,
    output logic             o_result_valid,
    output logic             o_result_owner,
    output logic             o_result_zero,
    output logic             o_op_err,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_lastOwner;
    logic             r_owner;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_gnt0;
    logic             r_gnt1;
    logic [WIDTH-1:0] r_result;
    logic             r_resultValid;
    logic             r_resultOwner;
    logic             r_resultZero;
    logic             r_opErr;
    logic             r_busy;

    logic             w_anyReq;
    logic             w_winner;
    logic             w_grant;
    logic [1:0]       w_winOp;
    logic [WIDTH-1:0] w_winA;
    logic [WIDTH-1:0] w_winB;
    logic [WIDTH-1:0] w_calc;
    logic             w_calcErr;

    // On a tie the requester that did not win last time goes next.
    // Arbitration happens from IDLE, or from DONE in the same cycle the
    // result is acknowledged, which gives back-to-back operation.
    always_comb begin
        w_anyReq = i_req0 | i_req1;
        w_winner = (i_req0 && i_req1) ? ~r_lastOwner : i_req1;
        w_grant  = w_anyReq &&
                   ((r_state == IDLE) || ((r_state == DONE) && i_result_ack));
        w_winOp  = w_winner ? i_op1 : i_op0;
        w_winA   = w_winner ? i_a1  : i_a0;
        w_winB   = w_winner ? i_b1  : i_b0;
    end

    // The logic unit operates on the latched operands only.
    always_comb begin
        w_calc    = '0;
        w_calcErr = 1'b0;
        case (r_op)
            2'b00:   w_calc = r_a & r_b;
            2'b01:   w_calc = r_a | r_b;
            2'b10:   w_calc = ~r_a;
            default: begin
`ifdef LOGIC_ARB_XOR_EN
                w_calc    = r_a ^ r_b;
                w_calcErr = 1'b0;
`else
                w_calc    = '0;
                w_calcErr = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_lastOwner   <= 1'b1;
            r_owner       <= 1'b0;
            r_op          <= 2'b00;
            r_a           <= '0;
            r_b           <= '0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_result      <= '0;
            r_resultValid <= 1'b0;
            r_resultOwner <= 1'b0;
            r_resultZero  <= 1'b0;
            r_opErr       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;

            if (w_grant) begin
                r_op        <= w_winOp;
                r_a         <= w_winA;
                r_b         <= w_winB;
                r_owner     <= w_winner;
                r_lastOwner <= w_winner;
                r_gnt0      <= ~w_winner;
                r_gnt1      <= w_winner;
                r_busy      <= 1'b1;
                r_state     <= EXEC;
            end

            case (r_state)
                IDLE: begin
                end
                EXEC: begin
                    r_result      <= w_calc;
                    r_resultValid <= 1'b1;
                    r_resultOwner <= r_owner;
                    r_resultZero  <= (w_calc == '0);
                    r_opErr       <= w_calcErr;
                    r_state       <= DONE;
                end
                DONE: begin
                    // The result value itself is left stale after the ack.
                    // Only the valid flag is dropped.
                    if (i_result_ack) begin
                        r_resultValid <= 1'b0;
                        if (!w_anyReq) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_gnt0         = r_gnt0;
    assign o_gnt1         = r_gnt1;
    assign o_result       = r_result;
    assign o_result_valid = r_resultValid;
    assign o_result_owner = r_resultOwner;
    assign o_result_zero  = r_resultZero;
    assign o_op_err       = r_opErr;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// ============================================================================
// tb_logic_unit_arbiter
//
// Purpose:
//   Self-checking bench for logic_unit_arbiter.
//   Expected results are pushed to a queue when a request is driven. They are
//   popped and compared when the DUT presents a valid result.
//   Inputs are driven and outputs sampled on the falling clock edge.
//
// Configuration:
//   LOGIC_ARB_XOR_EN  Must match the RTL build. It selects the expected
//                     behaviour of opcode 11.
// ============================================================================
module tb_logic_unit_arbiter;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         req0;
    logic [1:0]   op0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         req1;
    logic [1:0]   op1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         resultAck;
    logic         gnt0;
    logic         gnt1;
    logic [W-1:0] result;
    logic         resultValid;
    logic         resultOwner;
    logic         resultZero;
    logic         opErr;
    logic         busy;

    typedef struct packed {
        logic         owner;
        logic [W-1:0] res;
        logic         zero;
        logic         err;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    logic_unit_arbiter #(.WIDTH(W)) dut (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_req0         (req0),
        .i_op0          (op0),
        .i_a0           (a0),
        .i_b0           (b0),
        .i_req1         (req1),
        .i_op1          (op1),
        .i_a1           (a1),
        .i_b1           (b1),
        .i_result_ack   (resultAck),
        .o_gnt0         (gnt0),
        .o_gnt1         (gnt1),
        .o_result       (result),
        .o_result_valid (resultValid),
        .o_result_owner (resultOwner),
        .o_result_zero  (resultZero),
        .o_op_err       (opErr),
        .o_busy         (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model of one operation.
    function automatic exp_t model(input logic owner, input logic [1:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.owner = owner;
        e.err   = 1'b0;
        if (op == 2'b00)      e.res = a & b;
        else if (op == 2'b01) e.res = a | b;
        else if (op == 2'b10) e.res = ~a;
        else begin
`ifdef LOGIC_ARB_XOR_EN
            e.res = a ^ b;
`else
            e.res = '0;
            e.err = 1'b1;
`endif
        end
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic driveIdle();
        req0 = 1'b0; op0 = 2'b00; a0 = '0; b0 = '0;
        req1 = 1'b0; op1 = 2'b00; a1 = '0; b1 = '0;
        resultAck = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        driveIdle();
        repeat (2) @(negedge clock);
        checks++;
        if ({gnt0, gnt1, resultValid, resultOwner, resultZero, opErr, busy} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b, required 0000000",
                     {gnt0, gnt1, resultValid, resultOwner, resultZero, opErr, busy});
        end
        checks++;
        if (result !== '0) begin
            errors++;
            $display("[TB] FAIL reset_result: got %h, required 0", result);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_or_single();
        exp_t e;
        req0 = 1'b1; op0 = 2'b01; a0 = 32'h0000_F0F0; b0 = 32'h0F0F_0000;
        sbq.push_back(model(1'b0, op0, a0, b0));
        @(negedge clock);
        checks++;
        if ({gnt0, gnt1, busy, resultValid} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL or_grant: gnt0,gnt1,busy,valid got %b, required 1010",
                     {gnt0, gnt1, busy, resultValid});
        end
        req0 = 1'b0;
        @(negedge clock);
        checks++;
        if (resultValid !== 1'b1 || gnt0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL or_valid: valid,gnt0 got %b%b, required 10", resultValid, gnt0);
        end
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL or_sb: got empty queue, required an entry");
        end else begin
            e = sbq.pop_front();
            if ({resultOwner, result, resultZero, opErr} !== e) begin
                errors++;
                $display("[TB] FAIL or_result: got owner %b res %h z %b err %b, required owner %b res %h z %b err %b",
                         resultOwner, result, resultZero, opErr, e.owner, e.res, e.zero, e.err);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (resultValid !== 1'b1 || result !== 32'h0F0F_F0F0) begin
                errors++;
                $display("[TB] FAIL or_hold: valid %b res %h, required 1 0f0ff0f0", resultValid, result);
            end
        end
        resultAck = 1'b1;
        @(negedge clock);
        resultAck = 1'b0;
        checks++;
        if (resultValid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL or_ack: valid,busy got %b%b, required 00", resultValid, busy);
        end
    endtask

    task automatic test_tie_round_robin();
        exp_t e;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        req0 = 1'b1; op0 = 2'b00; a0 = 32'hFFFF_0000; b0 = 32'h00FF_FF00;
        req1 = 1'b1; op1 = 2'b10; a1 = 32'h1234_5678; b1 = 32'hDEAD_BEEF;
        sbq.push_back(model(1'b0, op0, a0, b0));
        sbq.push_back(model(1'b1, op1, a1, b1));
        @(negedge clock);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL tie_first: gnt0,gnt1 got %b, required 10", {gnt0, gnt1});
        end
        req0 = 1'b0;
        @(negedge clock);
        checks++;
        if (sbq.size() == 0 || resultValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tie_r0: valid %b queue %0d, required valid 1 and an entry", resultValid, sbq.size());
        end else begin
            e = sbq.pop_front();
            if ({resultOwner, result, resultZero, opErr} !== e) begin
                errors++;
                $display("[TB] FAIL tie_r0: got owner %b res %h, required owner %b res %h",
                         resultOwner, result, e.owner, e.res);
            end
        end
        resultAck = 1'b1;
        @(negedge clock);
        resultAck = 1'b0;
        req1 = 1'b0;
        checks++;
        if ({gnt0, gnt1, resultValid, busy} !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL tie_b2b: gnt0,gnt1,valid,busy got %b, required 0101",
                     {gnt0, gnt1, resultValid, busy});
        end
        @(negedge clock);
        checks++;
        if (sbq.size() == 0 || resultValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tie_r1: valid %b queue %0d, required valid 1 and an entry", resultValid, sbq.size());
        end else begin
            e = sbq.pop_front();
            if ({resultOwner, result, resultZero, opErr} !== e) begin
                errors++;
                $display("[TB] FAIL tie_r1: got owner %b res %h, required owner %b res %h",
                         resultOwner, result, e.owner, e.res);
            end
        end
        resultAck = 1'b1;
        @(negedge clock);
        resultAck = 1'b0;
        req0 = 1'b1; op0 = 2'b01; a0 = 32'h0000_0001; b0 = 32'h0000_0002;
        req1 = 1'b1; op1 = 2'b00; a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF;
        sbq.push_back(model(1'b0, op0, a0, b0));
        @(negedge clock);
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL tie_second: gnt0,gnt1 got %b, required 10", {gnt0, gnt1});
        end
        @(negedge clock);
        checks++;
        if (sbq.size() == 0 || resultValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tie_r2: valid %b queue %0d, required valid 1 and an entry", resultValid, sbq.size());
        end else begin
            e = sbq.pop_front();
            if ({resultOwner, result, resultZero, opErr} !== e) begin
                errors++;
                $display("[TB] FAIL tie_r2: got owner %b res %h, required owner %b res %h",
                         resultOwner, result, e.owner, e.res);
            end
        end
        resultAck = 1'b1;
        @(negedge clock);
        resultAck = 1'b0;
    endtask

    task automatic test_zero();
        exp_t e;
        req0 = 1'b1; op0 = 2'b00; a0 = 32'hAAAA_AAAA; b0 = 32'h5555_5555;
        sbq.push_back(model(1'b0, op0, a0, b0));
        @(negedge clock);
        req0 = 1'b0;
        @(negedge clock);
        checks++;
        if (resultZero !== 1'b1 || result !== '0 || resultValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_flag: valid %b z %b res %h, required 1 1 0", resultValid, resultZero, result);
        end
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL zero_sb: got empty queue, required an entry");
        end else begin
            e = sbq.pop_front();
            if ({resultOwner, result, resultZero, opErr} !== e) begin
                errors++;
                $display("[TB] FAIL zero_result: got owner %b res %h z %b, required owner %b res %h z %b",
                         resultOwner, result, resultZero, e.owner, e.res, e.zero);
            end
        end
        resultAck = 1'b1;
        @(negedge clock);
        resultAck = 1'b0;
    endtask

    task automatic test_op11();
        exp_t e;
        logic [W-1:0] expRes;
        logic         expErr;
`ifdef LOGIC_ARB_XOR_EN
        expRes = 32'hF0F0_0F0F; expErr = 1'b0;
`else
        expRes = 32'h0000_0000; expErr = 1'b1;
`endif
        req1 = 1'b1; op1 = 2'b11; a1 = 32'hFFFF_0000; b1 = 32'h0F0F_0F0F;
        sbq.push_back(model(1'b1, op1, a1, b1));
        @(negedge clock);
        req1 = 1'b0;
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL op11_grant: gnt0,gnt1 got %b, required 01", {gnt0, gnt1});
        end
        @(negedge clock);
        checks++;
        if (result !== expRes || opErr !== expErr || resultValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL op11_value: res %h err %b valid %b, required %h %b 1",
                     result, opErr, resultValid, expRes, expErr);
        end
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL op11_sb: got empty queue, required an entry");
        end else begin
            e = sbq.pop_front();
            if ({resultOwner, result, resultZero, opErr} !== e) begin
                errors++;
                $display("[TB] FAIL op11_result: got owner %b res %h z %b err %b, required owner %b res %h z %b err %b",
                         resultOwner, result, resultZero, opErr, e.owner, e.res, e.zero, e.err);
            end
        end
        resultAck = 1'b1;
        @(negedge clock);
        resultAck = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        req0 = 1'b1; op0 = 2'b01; a0 = 32'h1111_0000; b0 = 32'h0000_2222;
        sbq.push_back(model(1'b0, op0, a0, b0));
        @(negedge clock);
        req0 = 1'b0;
        req1 = 1'b1; op1 = 2'b10; a1 = 32'h0F0F_0F0F; b1 = 32'h0;
        sbq.push_back(model(1'b1, op1, a1, b1));
        @(negedge clock);
        checks++;
        if (sbq.size() == 0 || resultValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_r0: valid %b queue %0d, required valid 1 and an entry", resultValid, sbq.size());
        end else begin
            e = sbq.pop_front();
            if ({resultOwner, result, resultZero, opErr} !== e) begin
                errors++;
                $display("[TB] FAIL b2b_r0: got owner %b res %h, required owner %b res %h",
                         resultOwner, result, e.owner, e.res);
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (gnt1 !== 1'b0 || busy !== 1'b1 || resultValid !== 1'b1 || result !== 32'h1111_2222) begin
                errors++;
                $display("[TB] FAIL b2b_hold: gnt1 %b busy %b valid %b res %h, required 0 1 1 11112222",
                         gnt1, busy, resultValid, result);
            end
        end
        resultAck = 1'b1;
        @(negedge clock);
        resultAck = 1'b0;
        req1 = 1'b0;
        checks++;
        if ({gnt0, gnt1, resultValid, busy} !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL b2b_grant: gnt0,gnt1,valid,busy got %b, required 0101",
                     {gnt0, gnt1, resultValid, busy});
        end
        @(negedge clock);
        checks++;
        if (sbq.size() == 0 || resultValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_r1: valid %b queue %0d, required valid 1 and an entry", resultValid, sbq.size());
        end else begin
            e = sbq.pop_front();
            if ({resultOwner, result, resultZero, opErr} !== e) begin
                errors++;
                $display("[TB] FAIL b2b_r1: got owner %b res %h, required owner %b res %h",
                         resultOwner, result, e.owner, e.res);
            end
        end
        resultAck = 1'b1;
        @(negedge clock);
        resultAck = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        req0 = 1'b1; op0 = 2'b01; a0 = 32'hFFFF_FFFF; b0 = 32'h0;
        sbq.push_back(model(1'b0, op0, a0, b0));
        @(negedge clock);
        reset = 1'b1;
        sbq.delete();
        #1;
        checks++;
        if ({gnt0, gnt1, resultValid, resultOwner, resultZero, opErr, busy} !== 7'b0 || result !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: flags %b res %h, required 0000000 0",
                     {gnt0, gnt1, resultValid, resultOwner, resultZero, opErr, busy}, result);
        end
        @(negedge clock);
        req0 = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if ({gnt0, gnt1, resultValid, busy} !== 4'b0) begin
                errors++;
                $display("[TB] FAIL midreset_quiet: gnt0,gnt1,valid,busy got %b, required 0000",
                         {gnt0, gnt1, resultValid, busy});
            end
        end
        req1 = 1'b1; op1 = 2'b00; a1 = 32'hCAFE_F00D; b1 = 32'hFFFF_0000;
        sbq.push_back(model(1'b1, op1, a1, b1));
        @(negedge clock);
        req1 = 1'b0;
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL midreset_grant: gnt0,gnt1 got %b, required 01", {gnt0, gnt1});
        end
        @(negedge clock);
        checks++;
        if (sbq.size() == 0 || resultValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_r: valid %b queue %0d, required valid 1 and an entry", resultValid, sbq.size());
        end else begin
            e = sbq.pop_front();
            if ({resultOwner, result, resultZero, opErr} !== e) begin
                errors++;
                $display("[TB] FAIL midreset_r: got owner %b res %h, required owner %b res %h",
                         resultOwner, result, e.owner, e.res);
            end
        end
        resultAck = 1'b1;
        @(negedge clock);
        resultAck = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        driveIdle();
        test_reset();
        test_or_single();
        test_tie_round_robin();
        test_zero();
        test_op11();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: got %0d pending results, required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
